// File: rtl/dmem_rmw_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_rmw_ctrl_pkg
//   Shared RV32 constants for the data-memory path, also imported by the
//   rv32is core: load/store width encodings (funct3), the data-memory
//   controller state encoding, and the byte-lane helpers that both the
//   controller and the core's load path rely on.
// -----------------------------------------------------------------------------
package dmem_rmw_ctrl_pkg;

  localparam int WORD_W = 32;

  // RV32 funct3 for loads/stores. Stores use only the signed encodings.
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } memop_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LRESP = 3'd2,
    ST_MERGE = 3'd3,
    ST_WRITE = 3'd4
  } dmem_state_e;

  // An access is rejected when it is misaligned for its width, uses a
  // reserved funct3, or asks for an unsigned store (no such instruction).
  function automatic logic access_error(input logic [2:0] op,
                                        input logic       is_store,
                                        input logic [1:0] boff);
    logic bad;
    bad = 1'b1;
    case (op)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = boff[0];
      MEM_W:   bad = (boff != 2'b00);
      MEM_BU:  bad = is_store;
      MEM_HU:  bad = is_store | boff[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [WORD_W-1:0] load_extract(input logic [WORD_W-1:0] word,
                                                     input logic [2:0]        op,
                                                     input logic [1:0]        boff);
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [WORD_W-1:0] res;
    byte_v = word[{boff, 3'b000} +: 8];
    half_v = word[{boff[1], 4'b0000} +: 16];
    res    = word;
    case (op)
      MEM_B:   res = {{24{byte_v[7]}}, byte_v};
      MEM_BU:  res = {24'h000000, byte_v};
      MEM_H:   res = {{16{half_v[15]}}, half_v};
      MEM_HU:  res = {16'h0000, half_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/half lanes of a word with store data.
  function automatic logic [WORD_W-1:0] store_merge(input logic [WORD_W-1:0] word,
                                                    input logic [WORD_W-1:0] sdata,
                                                    input logic [2:0]        op,
                                                    input logic [1:0]        boff);
    logic [WORD_W-1:0] res;
    res = word;
    case (op)
      MEM_B:   res[{boff, 3'b000} +: 8]     = sdata[7:0];
      MEM_H:   res[{boff[1], 4'b0000} +: 16] = sdata[15:0];
      default: res = sdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_rmw_ctrl_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
//   Single-port 2^ADDR_WIDTH x 32 data RAM. Synchronous write, registered
//   read (data appears the cycle after re). The array is named ram so a
//   bench can preload or inspect it.
//
//   clock  : clock
//   we     : write enable, writes wdata to ram[addr]
//   re     : read enable, loads ram[addr] into rdata
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module dmem_ram
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] ram [0:(1<<ADDR_WIDTH)-1];

  // NOTE: memory arrays carry no reset; a reset loop over every word would
  // stop the array from mapping onto RAM macros, and contents must survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      ram[addr] <= wdata;
    end
    if (re) begin
      rdata <= ram[addr];
    end
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_rmw_ctrl
//   Data-memory controller for the RV32 core. Word stores go straight to the
//   RAM; loads read the word and extract/extend the addressed lanes; byte
//   and half stores do a read-modify-write of the containing word.
//   Rejected accesses (misaligned or illegal funct3) complete with err.
//
//   clock  : clock, all state changes on posedge
//   reset  : synchronous active-high reset
//   req    : access request, only sampled while ready=1
//   addr   : byte address (bits above ADDR_WIDTH+1 ignored)
//   memop  : RV32 funct3 width/sign
//   we     : 1 = store, 0 = load
//   wdata  : store data, sub-word taken from the low bits
//   ready  : controller idle and able to accept
//   ack    : one-cycle completion pulse
//   err    : access rejected (only with ack)
//   rdata  : load result, valid with ack, held until the next load ack
// -----------------------------------------------------------------------------
module dmem_rmw_ctrl
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [31:0]       addr,
  input  logic [2:0]        memop,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              ack,
  output logic              err,
  output logic [WORD_W-1:0] rdata
);

  dmem_state_e state;

  // Latched request
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            memop_q;
  logic                  we_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  err_q;

  logic [WORD_W-1:0]     rdata_q;

  logic                  accept;
  logic                  acc_err;
  logic [WORD_W-1:0]     load_val;
  logic                  load_done;

  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_W-1:0]     ram_wdata;
  logic [WORD_W-1:0]     ram_rdata;

  // Address bits beyond the memory size are dropped so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // ready and ack are gated by reset so a reset landing mid-access neither
  // accepts a new request nor reports a completion that never happens.
  assign ready   = (state == ST_IDLE) && !reset;
  assign accept  = req && ready;
  assign acc_err = access_error(memop, we, addr[1:0]);

  assign ack = !reset && ((state == ST_LRESP) ||
                          (state == ST_MERGE) ||
                          (state == ST_WRITE));
  assign err = ack && err_q;

  // The RAM's registered read lands at the start of LRESP, so the extracted
  // value is forwarded in the ack cycle and captured into rdata_q for holding.
  assign load_val  = load_extract(ram_rdata, memop_q, addr_q[1:0]);
  assign load_done = ack && (state == ST_LRESP) && !err_q;
  assign rdata     = load_done ? load_val : rdata_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err_q <= acc_err;
            if (acc_err) begin
              state <= ST_LRESP;
            end else if (we && (memop == MEM_W)) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state <= we_q ? ST_MERGE : ST_LRESP;
        end
        ST_LRESP: begin
          if (!err_q) begin
            rdata_q <= load_val;
          end
          state <= ST_IDLE;
        end
        ST_MERGE: state <= ST_IDLE;
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Request fields are pure datapath: they are only consumed after an accept
  // has loaded them, so they need no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= addr[ADDR_WIDTH+1:0];
      memop_q <= memop;
      we_q    <= we;
      wdata_q <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port
  // ---------------------------------------------------------------------------
  assign ram_addr  = addr_q[ADDR_WIDTH+1:2];
  assign ram_re    = (state == ST_READ);
  // Errors never reach MERGE/WRITE, so only reset needs to block the write.
  assign ram_we    = !reset && ((state == ST_MERGE) || (state == ST_WRITE));
  assign ram_wdata = (state == ST_MERGE)
                     ? store_merge(ram_rdata, wdata_q, memop_q, addr_q[1:0])
                     : wdata_q;

  dmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_rmw_ctrl
//   Directed bench for dmem_rmw_ctrl. Each access pushes its expected
//   completion (latency, err, rdata) to a scoreboard queue; the entry is
//   popped and compared when ack is seen. RAM words are checked against
//   constants through the ram array.
// -----------------------------------------------------------------------------
module tb_dmem_rmw_ctrl;

  localparam int AW = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [2:0]  memop;
  logic        we;
  logic [31:0] wdata;
  logic        ready;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] last_rd;

  always #5 clock = ~clock;

  dmem_rmw_ctrl #(
    .ADDR_WIDTH(AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .addr  (addr),
    .memop (memop),
    .we    (we),
    .wdata (wdata),
    .ready (ready),
    .ack   (ack),
    .err   (err),
    .rdata (rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the controller idle; returns at the negedge of
  // the idle cycle following the ack. With hold=1, req stays high with a
  // different address until the ack cycle, which must not start a new access.
  task automatic access(input string tag, input logic [31:0] a, input logic [2:0] op,
                        input logic w, input logic [31:0] d, input logic exp_err,
                        input logic [31:0] exp_rd, input int exp_lat, input logic hold);
    exp_t e;
    logic got;
    int   lat;
    exp_q.push_back('{lat: exp_lat, err: exp_err, rd: exp_rd});
    check({tag, ".ready"}, {31'd0, ready}, 32'd1);
    req   = 1'b1;
    addr  = a;
    memop = op;
    we    = w;
    wdata = d;
    @(posedge clock);
    #1;
    if (hold) addr = a ^ 32'h0000_0040;
    else      req  = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clock);
      if (ack) begin
        got = 1'b1;
        lat = i;
      end
    end
    req = 1'b0;
    check({tag, ".ack_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      e = exp_q.pop_front();
      check({tag, ".latency"}, lat, e.lat);
      check({tag, ".err"}, {31'd0, err}, {31'd0, e.err});
      check({tag, ".rdata"}, rdata, e.rd);
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clock);
    check({tag, ".no_extra_ack"}, {31'd0, ack}, 32'd0);
    check({tag, ".ready_after"}, {31'd0, ready}, 32'd1);
    last_rd = exp_rd;
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    addr  = '0;
    memop = '0;
    we    = 1'b0;
    wdata = '0;
    last_rd = '0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst.ready", {31'd0, ready}, 32'd0);
    check("rst.ack",   {31'd0, ack},   32'd0);
    check("rst.err",   {31'd0, err},   32'd0);
    check("rst.rdata", rdata, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst.ready_after", {31'd0, ready}, 32'd1);

    // sw then lw
    access("sw_1234",  32'h8014, 3'b010, 1'b1, 32'd1234, 1'b0, 32'h0,        1, 1'b0);
    check("word_8014", dut.u_ram.ram[15'h2005], 32'h0000_04D2);
    access("lw_8014",  32'h8014, 3'b010, 1'b0, 32'h0,    1'b0, 32'h0000_04D2, 2, 1'b0);

    // Byte store into a zeroed word, signed/unsigned byte loads
    access("sw0_8018", 32'h8018, 3'b010, 1'b1, 32'h0,         1'b0, last_rd, 1, 1'b0);
    access("sb_ff",    32'h8018, 3'b000, 1'b1, 32'hABCD_EFFF, 1'b0, last_rd, 2, 1'b0);
    check("word_8018", dut.u_ram.ram[15'h2006], 32'h0000_00FF);
    access("lb_8018",  32'h8018, 3'b000, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF, 2, 1'b0);
    access("lbu_8018", 32'h8018, 3'b100, 1'b0, 32'h0, 1'b0, 32'h0000_00FF, 2, 1'b0);

    // Assemble a word from four byte stores
    access("sw0_801c", 32'h801C, 3'b010, 1'b1, 32'h0,  1'b0, last_rd, 1, 1'b0);
    access("sb_78",    32'h801C, 3'b000, 1'b1, 32'h78, 1'b0, last_rd, 2, 1'b0);
    access("sb_56",    32'h801D, 3'b000, 1'b1, 32'h56, 1'b0, last_rd, 2, 1'b0);
    access("sb_34",    32'h801E, 3'b000, 1'b1, 32'h34, 1'b0, last_rd, 2, 1'b0);
    access("sb_12",    32'h801F, 3'b000, 1'b1, 32'h12, 1'b0, last_rd, 2, 1'b0);
    check("word_801c", dut.u_ram.ram[15'h2007], 32'h1234_5678);
    // req held high through READ/LRESP with another address: ignored
    access("lw_801c_hold", 32'h801C, 3'b010, 1'b0, 32'h0, 1'b0, 32'h1234_5678, 2, 1'b1);
    access("lh_801e",  32'h801E, 3'b001, 1'b0, 32'h0, 1'b0, 32'h0000_1234, 2, 1'b0);
    access("lhu_801c", 32'h801C, 3'b101, 1'b0, 32'h0, 1'b0, 32'h0000_5678, 2, 1'b0);
    access("lb_801f",  32'h801F, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0000_0012, 2, 1'b0);

    // Half store into the upper lane, then signed/unsigned half loads
    access("sh_beef",  32'h801E, 3'b001, 1'b1, 32'h8000_BEEF, 1'b0, last_rd, 2, 1'b0);
    check("word_801c_sh", dut.u_ram.ram[15'h2007], 32'hBEEF_5678);
    access("lh_beef",  32'h801E, 3'b001, 1'b0, 32'h0, 1'b0, 32'hFFFF_BEEF, 2, 1'b0);
    access("lhu_beef", 32'h801E, 3'b101, 1'b0, 32'h0, 1'b0, 32'h0000_BEEF, 2, 1'b0);

    // Rejected accesses: 1-cycle ack with err, rdata and memory untouched
    access("lh_mis",   32'h8019, 3'b001, 1'b0, 32'h0,         1'b1, last_rd, 1, 1'b0);
    access("sw_mis",   32'h801A, 3'b010, 1'b1, 32'hDEAD_BEEF, 1'b1, last_rd, 1, 1'b0);
    check("word_8018_mis", dut.u_ram.ram[15'h2006], 32'h0000_00FF);
    access("op_011",   32'h8014, 3'b011, 1'b0, 32'h0,         1'b1, last_rd, 1, 1'b0);
    access("sbu_ill",  32'h8018, 3'b100, 1'b1, 32'h0000_0011, 1'b1, last_rd, 1, 1'b0);
    check("word_8018_ill", dut.u_ram.ram[15'h2006], 32'h0000_00FF);

    // Address wraps modulo the memory size
    access("lw_wrap",  32'h0002_8014, 3'b010, 1'b0, 32'h0, 1'b0, 32'h0000_04D2, 2, 1'b0);

    // Reset while in MERGE of sb 0xAA: write suppressed, no ack
    check("mrst.ready", {31'd0, ready}, 32'd1);
    req   = 1'b1;
    addr  = 32'h8018;
    memop = 3'b000;
    we    = 1'b1;
    wdata = 32'h0000_00AA;
    @(posedge clock);
    #1;
    req = 1'b0;
    @(negedge clock);              // READ
    check("mrst.read_ack", {31'd0, ack}, 32'd0);
    @(negedge clock);              // MERGE
    reset = 1'b1;
    #1;
    check("mrst.ack",   {31'd0, ack},   32'd0);
    check("mrst.ready", {31'd0, ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mrst.word",        dut.u_ram.ram[15'h2006], 32'h0000_00FF);
    check("mrst.ready_after", {31'd0, ready}, 32'd1);
    check("mrst.ack_after",   {31'd0, ack},   32'd0);
    check("mrst.rdata",       rdata, 32'd0);
    last_rd = 32'd0;
    @(negedge clock);
    access("lbu_after_rst", 32'h8018, 3'b100, 1'b0, 32'h0, 1'b0, 32'h0000_00FF, 2, 1'b0);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_rmw_ctrl.md
DMEM_RMW_CTRL -- requirements
Module: dmem_rmw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, meaning the number of word-address bits (32K words); byte address bits [ADDR_WIDTH+1:2] select the word.
REQ-002 SHALL have port clock, input, 1: the single clock; all state changes on posedge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 1: CPU access request, sampled only while ready=1.
REQ-005 SHALL have port addr, input, 32: byte address.
REQ-006 SHALL have port memop, input, 3: RV32 funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 SHALL have port we, input, 1: 1=store, 0=load.
REQ-008 SHALL have port wdata, input, 32: store data, with the sub-word taken from the low bits.
REQ-009 SHALL have port ready, output, 1: high only in IDLE.
REQ-010 SHALL have port ack, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1: qualifies ack when the access was rejected.
REQ-012 SHALL have port rdata, output, 32: load result, valid with ack, held until the next load ack.

Function
REQ-013 SHALL latch addr/memop/we/wdata when req=1 and ready=1.
REQ-014 SHALL implement FSM states IDLE, READ, LRESP, MERGE, WRITE; all accepted paths return to IDLE.
REQ-015 SHALL transition IDLE->WRITE for sw, IDLE->READ for loads and sb/sh, READ->LRESP for loads, and READ->MERGE for sb/sh.
REQ-016 SHALL issue the RAM read of the latched word in READ; the data is available in the following state.
REQ-017 SHALL, in LRESP, extract the byte/half at addr[1:0]/addr[1], sign-extend for b/h, zero-extend for bu/hu, pass w unchanged, register the result into rdata, and pulse ack.
REQ-018 SHALL, in MERGE, replace only the addressed byte/half lanes of the read word with wdata[7:0]/[15:0], write the word, and pulse ack.
REQ-019 SHALL, in WRITE, write wdata to the word and pulse ack.
REQ-020 SHALL give latency from the accept edge to ack: sw 1 cycle; loads, sb and sh 2 cycles; the next accept is possible in the cycle after ack.
REQ-021 SHALL ignore req while ready=0: no queuing, no effect.
REQ-022 SHALL treat misaligned h (addr[0]=1), misaligned w (addr[1:0]!=0), and illegal memop (011, 110, 111, and 1xx with we=1) as errors: IDLE->LRESP directly, ack=1 and err=1, no RAM write, rdata unchanged.
REQ-023 SHALL ignore address bits above ADDR_WIDTH+1, so the address wraps modulo the memory size.
REQ-024 SHALL drive err=0 whenever ack=0.

Reset
REQ-025 SHALL, when reset=1 at a posedge, force the state to IDLE, and drive rdata=0, ack=0, err=0.
REQ-026 SHALL drive ready=0 during any cycle in which reset=1 and ready=1 the cycle after reset deasserts.
REQ-027 SHALL suppress the RAM write when reset is asserted in MERGE or WRITE, leaving the word unchanged.
REQ-028 SHALL NOT clear RAM contents on reset; they are loadable only by bench preload.

Structure
REQ-029 SHALL take the memop encodings and the FSM state encoding from the shared rv32 constants package/include, which is also used by rv32is.
REQ-030 SHALL instantiate one sub-module, dmem_ram: single-port 2^ADDR_WIDTH x 32 RAM with synchronous write, registered read, and array named ram for bench preload and inspection.

Verification
REQ-031 SHALL cover: sw 1234 @0x8014, then lw @0x8014 -> ack 1 cycle after the store accept, and rdata=0x000004D2 2 cycles after the load accept.
REQ-032 SHALL cover: sw 0 @0x8018, sb 0xFF @0x8018, then lb -> rdata=0xFFFFFFFF and lbu -> 0x000000FF, with the word equal to 0x000000FF.
REQ-033 SHALL cover: sb 0x78/0x56/0x34/0x12 @0x801C..0x801F on a zeroed word -> word 0x12345678; lw -> 0x12345678; lh @0x801E -> 0x00001234.
REQ-034 SHALL cover: lh @0x8019 and sw @0x801A -> ack=1 and err=1 1 cycle after accept, memory and rdata unchanged.
REQ-035 SHALL cover: reset asserted while in MERGE of sb 0xAA @0x8018 -> word unchanged, ack=0, and ready=1 the cycle after reset deasserts.
REQ-036 SHALL cover: req held high during READ/LRESP with a different address -> ignored; exactly one ack per accept.
